// File: rtl/rf_biu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_biu_pkg
//  Purpose  : Shared types for the rf8088/rf80386 bus interface unit. Holds
//             the FTA 128-bit command request/response structures, the BIU
//             state enumeration, access-size encodings and the lane-mask helper.
//  Revision : 1.0  initial release
// ============================================================================
package rf_biu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CYC1 = 3'd1,
        GAP  = 3'd2,
        CYC2 = 3'd3,
        DONE = 3'd4
    } e_biu_state;

    localparam logic [1:0] BIU_BYTE  = 2'd0;
    localparam logic [1:0] BIU_WORD  = 2'd1;
    localparam logic [1:0] BIU_DWORD = 2'd2;

    typedef enum logic [1:0] {
        LINEAR = 2'd0,
        WRAP4  = 2'd1,
        WRAP8  = 2'd2,
        WRAP16 = 2'd3
    } fta_bte_t;

    typedef enum logic [2:0] {
        CLASSIC = 3'd0,
        FIXED   = 3'd1,
        INCR    = 3'd2,
        EOB     = 3'd7
    } fta_cti_t;

    typedef struct packed {
        logic [5:0] core;
        logic [2:0] channel;
        logic [3:0] tranid;
    } fta_tranid_t;

    typedef struct packed {
        fta_tranid_t    tid;
        logic [5:0]     blen;
        fta_bte_t       bte;
        fta_cti_t       cti;
        logic           cyc;
        logic           stb;
        logic           we;
        logic [15:0]    sel;
        logic [31:0]    vadr;
        logic [31:0]    padr;
        logic [127:0]   data1;
    } fta_cmd_request128_t;

    typedef struct packed {
        fta_tranid_t    tid;
        logic           ack;
        logic           rty;
        logic           err;
        logic [127:0]   dat;
    } fta_cmd_response128_t;

    // Byte-lane mask covering len bytes starting at lane off; lanes past 15
    // fall off the top.
    function automatic logic [15:0] lane_mask(input logic [3:0] off, input logic [2:0] len);
        logic [31:0] m;
        m = (32'd1 << len) - 32'd1;
        return 16'(m << off);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_biu_lane_steer.sv
`default_nettype none
// ============================================================================
//  Module   : rf_biu_lane_steer
//  Purpose  : Combinational byte-lane steering for one bus-cycle part.
//             Places the part's write bytes onto their 16-byte line lanes and
//             brings the addressed read lanes back down to byte order.
//  Ports    : off     - lane of the first byte of the part
//             len     - number of bytes in the part (1..4)
//             wdat    - part write bytes, first byte in bits [7:0]
//             bus_dat - 128-bit read data from the bus response
//             sel     - byte-lane select
//             data1   - 128-bit lane-aligned write data, unused lanes 0
//             rbytes  - read bytes of the part, first byte in bits [7:0]
//  Revision : 1.0  initial release
// ============================================================================
module rf_biu_lane_steer
    import rf_biu_pkg::*;
(
    input  logic [3:0]   off,
    input  logic [2:0]   len,
    input  logic [31:0]  wdat,
    input  logic [127:0] bus_dat,
    output logic [15:0]  sel,
    output logic [127:0] data1,
    output logic [31:0]  rbytes
);

    logic [31:0] w_bmask;   // bit-level mask of the bytes belonging to the part
    logic [6:0]  w_bitoff;

    always_comb begin
        w_bmask = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < len) w_bmask[i*8 +: 8] = 8'hFF;
        end
    end

    assign w_bitoff = {off, 3'b000};
    assign sel      = lane_mask(off, len);
    assign data1    = {96'd0, wdat & w_bmask} << w_bitoff;
    assign rbytes   = 32'(bus_dat >> w_bitoff) & w_bmask;

endmodule
`default_nettype wire

// File: rtl/rf_fta_biu.sv
`default_nettype none
// ============================================================================
//  Module   : rf_fta_biu
//  Purpose  : Bus interface unit converting one CPU byte/word/dword access at
//             any alignment into one or two FTA 128-bit classic bus cycles,
//             with line-crossing split, rty retry with limit and tranid
//             sequencing.
//  Ports    : clk_i/rst_i          - clock, synchronous active-high reset
//             req_i/we_i/size_i    - access request, direction, size
//             adr_i/wdat_i         - byte address, little-endian write data
//             busy_o/rdy_o/err_o   - in progress, completion, abort pulses
//             rdat_o               - zero-extended read data
//             ftam_req/ftam_resp   - FTA master request / response
//  Revision : 1.0  initial release
// ============================================================================
module rf_fta_biu
    import rf_biu_pkg::*;
#(
    parameter logic [5:0] CORENO  = 6'd1,
    parameter logic [2:0] CID     = 3'd1,
    parameter int         AWID    = 20,
    parameter logic [3:0] RTY_MAX = 4'd15
)(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [1:0]           size_i,
    input  logic [AWID-1:0]      adr_i,
    input  logic [31:0]          wdat_i,
    output logic                 busy_o,
    output logic                 rdy_o,
    output logic [31:0]          rdat_o,
    output logic                 err_o,
    output fta_cmd_request128_t  ftam_req,
    input  fta_cmd_response128_t ftam_resp
);

    e_biu_state      r_state;
    e_biu_state      w_next;

    logic            r_we;
    logic [1:0]      r_size;
    logic [AWID-1:0] r_adr;
    logic [31:0]     r_wdat;
    logic            r_part2;    // second part of a split access is current
    logic            r_retry;    // last cycle got rty and must be reissued
    logic [4:0]      r_rty_cnt;
    logic [3:0]      r_tranid;
    logic [31:0]     r_res;
    logic [31:0]     r_rdat;
    logic            r_err;

    logic [2:0]      w_n;
    logic [3:0]      w_off;
    logic            w_split;
    logic [2:0]      w_len1;
    logic [2:0]      w_len2;
    logic [AWID-1:0] w_adr2;
    logic [AWID-1:0] w_cur_adr;
    logic [3:0]      w_cur_off;
    logic [2:0]      w_cur_len;
    logic [31:0]     w_cur_wdat;
    logic [2:0]      w_base;     // byte position of the current part in the result
    logic [31:0]     w_padr;
    logic [15:0]     w_sel;
    logic [127:0]    w_data1;
    logic [31:0]     w_rbytes;
    logic [31:0]     w_rmask;
    logic [31:0]     w_rsh;
    logic            w_cyc;
    logic            w_rty_over;
    logic [3:0]      w_tranid_nx;
    logic            w_unused;

    // ---------------------------------------------------------------- split
    assign w_n     = 3'd1 << r_size;
    assign w_off   = r_adr[3:0];
    assign w_split = ({1'b0, w_off} + {2'b00, w_n}) > 5'd16;
    assign w_len1  = w_split ? 3'(5'd16 - {1'b0, w_off}) : w_n;
    assign w_len2  = w_n - w_len1;
    // Start of the next 16-byte line, wrapping at the top of the address space
    assign w_adr2  = (r_adr | AWID'(4'hF)) + AWID'(1);

    assign w_cur_adr  = r_part2 ? w_adr2 : r_adr;
    assign w_cur_off  = r_part2 ? 4'd0   : w_off;
    assign w_cur_len  = r_part2 ? w_len2 : w_len1;
    assign w_cur_wdat = r_part2 ? (r_wdat >> {w_len1, 3'b000}) : r_wdat;
    assign w_base     = r_part2 ? w_len1 : 3'd0;
    assign w_padr     = 32'(w_cur_adr);

    rf_biu_lane_steer u_steer (
        .off     (w_cur_off),
        .len     (w_cur_len),
        .wdat    (w_cur_wdat),
        .bus_dat (ftam_resp.dat),
        .sel     (w_sel),
        .data1   (w_data1),
        .rbytes  (w_rbytes)
    );

    // Result-register bytes written by the current part
    always_comb begin
        w_rmask = '0;
        for (int i = 0; i < 4; i++) begin
            if ((i >= int'(w_base)) && (i < int'(w_base) + int'(w_cur_len)))
                w_rmask[i*8 +: 8] = 8'hFF;
        end
    end
    assign w_rsh = w_rbytes << {w_base, 3'b000};

    assign w_rty_over  = (r_rty_cnt + 5'd1) > {1'b0, RTY_MAX};
    assign w_tranid_nx = (r_tranid == 4'd15) ? 4'd1 : r_tranid + 4'd1;

    // ------------------------------------------------------------ next state
    always_comb begin
        w_next = r_state;
        w_cyc  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req_i && (size_i != 2'd3)) w_next = CYC1;
            end
            CYC1, CYC2: begin
                w_cyc = 1'b1;
                if (ftam_resp.ack)      w_next = GAP;
                else if (ftam_resp.rty) w_next = w_rty_over ? IDLE : GAP;
            end
            GAP: begin
                if (r_retry)                 w_next = r_part2 ? CYC2 : CYC1;
                else if (w_split && !r_part2) w_next = CYC2;
                else                         w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_size    <= 2'd0;
            r_adr     <= '0;
            r_wdat    <= '0;
            r_part2   <= 1'b0;
            r_retry   <= 1'b0;
            r_rty_cnt <= '0;
            r_tranid  <= 4'd1;
            r_res     <= '0;
            r_rdat    <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (req_i) begin
                        if (size_i == 2'd3) begin
                            r_err <= 1'b1;
                        end else begin
                            r_we      <= we_i;
                            r_size    <= size_i;
                            r_adr     <= adr_i;
                            r_wdat    <= wdat_i;
                            r_part2   <= 1'b0;
                            r_retry   <= 1'b0;
                            r_rty_cnt <= '0;
                            r_res     <= '0;
                        end
                    end
                end
                CYC1, CYC2: begin
                    if (ftam_resp.ack) begin
                        r_tranid  <= w_tranid_nx;
                        r_res     <= (r_res & ~w_rmask) | w_rsh;
                        r_retry   <= 1'b0;
                        r_rty_cnt <= '0;
                    end else if (ftam_resp.rty) begin
                        r_tranid  <= w_tranid_nx;
                        r_retry   <= 1'b1;
                        r_rty_cnt <= r_rty_cnt + 5'd1;
                        if (w_rty_over) r_err <= 1'b1;
                    end
                end
                GAP: begin
                    if (w_next == CYC2) r_part2 <= 1'b1;
                    if (w_next == DONE) r_rdat  <= r_res;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    assign busy_o = (r_state != IDLE);
    assign rdy_o  = (r_state == DONE);
    assign rdat_o = r_rdat;
    assign err_o  = r_err;

    always_comb begin
        ftam_req             = '0;
        ftam_req.tid.core    = CORENO;
        ftam_req.tid.channel = CID;
        ftam_req.tid.tranid  = r_tranid;
        ftam_req.blen        = '0;
        ftam_req.bte         = LINEAR;
        ftam_req.cti         = CLASSIC;
        if (w_cyc) begin
            ftam_req.cyc   = 1'b1;
            ftam_req.stb   = 1'b1;
            ftam_req.we    = r_we;
            ftam_req.sel   = w_sel;
            ftam_req.padr  = w_padr;
            ftam_req.vadr  = w_padr;
            ftam_req.data1 = w_data1;
        end
    end

    assign w_unused = ^{ftam_resp.tid, ftam_resp.err};

endmodule
`default_nettype wire

// File: tb/tb_rf_fta_biu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_fta_biu
//  Purpose  : Self-checking bench for rf_fta_biu (AWID=32, RTY_MAX=2) with a
//             byte-addressed slave memory and a byte-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_fta_biu;
    import rf_biu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'd0;
    logic [31:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        busy, rdy, err;
    logic [31:0] rdat;
    fta_cmd_request128_t  ftam_req;
    fta_cmd_response128_t ftam_resp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rf_fta_biu #(.CORENO(6'd1), .CID(3'd1), .AWID(32), .RTY_MAX(4'd2)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
        .adr_i(adr), .wdat_i(wdat), .busy_o(busy), .rdy_o(rdy), .rdat_o(rdat),
        .err_o(err), .ftam_req(ftam_req), .ftam_resp(ftam_resp)
    );

    // ------------------------------------------------------------ slave model
    typedef struct packed {
        logic [31:0]  padr;
        logic [15:0]  sel;
        logic [127:0] data;
    } iss_t;

    bit [7:0]   mem [bit [31:0]];
    iss_t       acked[$];
    logic [3:0] iss_tid[$];
    int  max_wait = 0, rty_plan = 0, rty_left = 0, resp_budget = -1, wait_cnt = 0;
    bit  always_rty = 0, ack_with_rty = 0, in_cyc = 0;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h3C;
    endfunction

    always @(negedge clk) begin
        logic [31:0] base;
        ftam_resp = '0;
        if (rst) begin
            in_cyc = 0;
        end else if (ftam_req.cyc && ftam_req.stb) begin
            if (!in_cyc) begin
                in_cyc   = 1;
                wait_cnt = int'($urandom_range(max_wait, 0));
                iss_tid.push_back(ftam_req.tid.tranid);
            end
            if (resp_budget != 0) begin
                if (wait_cnt == 0) begin
                    ftam_resp.tid = ftam_req.tid;
                    if (always_rty || rty_left > 0) begin
                        ftam_resp.rty = 1'b1;
                        if (!always_rty) rty_left--;
                    end else begin
                        base = {ftam_req.padr[31:4], 4'h0};
                        ftam_resp.ack = 1'b1;
                        ftam_resp.rty = ack_with_rty && ($urandom_range(1, 0) == 1);
                        for (int l = 0; l < 16; l++) begin
                            ftam_resp.dat[l*8 +: 8] = mem_rd(base + 32'(l));
                            if (ftam_req.we && ftam_req.sel[l])
                                mem[base + 32'(l)] = ftam_req.data1[l*8 +: 8];
                        end
                        acked.push_back('{ftam_req.padr, ftam_req.sel, ftam_req.data1});
                        rty_left = rty_plan;
                    end
                    in_cyc = 0;
                    if (resp_budget > 0) resp_budget--;
                end else begin
                    wait_cnt--;
                end
            end
        end else begin
            in_cyc = 0;
        end
    end

    // ------------------------------------------------------- reference model
    int           exp_np;
    logic [31:0]  exp_pa [2];
    logic [15:0]  exp_ps [2];
    logic [127:0] exp_pd [2];
    logic [31:0]  exp_rd;
    logic [3:0]   exp_tid = 4'd1;

    // Walk the accessed bytes in address order; each new 16-byte line opens a part.
    function automatic void model_access(input logic [1:0] sz, input logic [31:0] a,
                                         input logic [31:0] d);
        logic [31:0] ba;
        int lane;
        exp_np = 0;
        exp_rd = '0;
        for (int i = 0; i < (1 << sz); i++) begin
            ba   = a + 32'(i);
            lane = int'(ba[3:0]);
            if (i == 0 || lane == 0) begin
                exp_pa[exp_np] = ba;
                exp_ps[exp_np] = '0;
                exp_pd[exp_np] = '0;
                exp_np++;
            end
            exp_ps[exp_np-1][lane]        = 1'b1;
            exp_pd[exp_np-1][lane*8 +: 8] = d[i*8 +: 8];
            exp_rd[i*8 +: 8]              = mem_rd(ba);
        end
    endfunction

    function automatic logic [3:0] tid_next(input logic [3:0] t);
        return (t == 4'd15) ? 4'd1 : t + 4'd1;
    endfunction

    // ---------------------------------------------------------------- driver
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] d, output int n_rdy, output int n_err,
                              output int lat, output int n_cyc, output logic busy1,
                              output logic [31:0] rd);
        acked.delete();
        iss_tid.delete();
        rty_left = rty_plan;
        req = 1'b1; we = w; size = sz; adr = a; wdat = d;
        tick();
        req = 1'b0;
        n_rdy = 0; n_err = 0; lat = 0; n_cyc = 0; rd = '0; busy1 = busy;
        for (int c = 1; c <= 300; c++) begin
            if (ftam_req.cyc) n_cyc++;
            if (rdy) begin n_rdy++; rd = rdat; if (lat == 0) lat = c; end
            if (err) begin n_err++; if (lat == 0) lat = c; end
            if (!busy && !rdy && !err && (n_rdy + n_err) > 0) break;
            tick();
        end
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        tests++; if ({busy, rdy, err} !== 3'b000) begin fails++; $display("FAIL reset_flags: busy/rdy/err=%b required 000", {busy, rdy, err}); end
        tests++; if (rdat !== 32'h0) begin fails++; $display("FAIL reset_rdat: got %h required 0", rdat); end
        tests++; if ({ftam_req.cyc, ftam_req.stb, ftam_req.we, ftam_req.sel} !== 19'h0) begin fails++; $display("FAIL reset_bus: cyc/stb/we/sel=%h required 0", {ftam_req.cyc, ftam_req.stb, ftam_req.we, ftam_req.sel}); end
        tests++; if (ftam_req.tid !== {6'd1, 3'd1, 4'd1}) begin fails++; $display("FAIL reset_tid: got %h required %h", ftam_req.tid, {6'd1, 3'd1, 4'd1}); end
        tests++; if ({ftam_req.padr, ftam_req.data1} !== '0) begin fails++; $display("FAIL reset_fields: padr=%h data1=%h required 0", ftam_req.padr, ftam_req.data1); end
        rst = 1'b0;
        exp_tid = 4'd1;
        tick();
    endtask

    task automatic test_byte_read();
        int nr, ne, lat, nc; logic b1; logic [31:0] rd;
        mem[32'h12345] = 8'hA5;
        max_wait = 0; rty_plan = 0;
        run_access(1'b0, BIU_BYTE, 32'h12345, 32'h0, nr, ne, lat, nc, b1, rd);
        tests++; if (b1 !== 1'b1) begin fails++; $display("FAIL byte_busy: got %b required 1", b1); end
        tests++; if (nr != 1 || ne != 0) begin fails++; $display("FAIL byte_done: rdy=%0d err=%0d required 1/0", nr, ne); end
        tests++; if (lat != 3) begin fails++; $display("FAIL byte_latency: got %0d required 3", lat); end
        tests++; if (rd !== 32'h000000A5) begin fails++; $display("FAIL byte_rdat: got %h required 000000a5", rd); end
        tests++; if (acked.size() != 1 || acked[0].sel !== 16'h0020 || acked[0].padr !== 32'h12345) begin
            fails++; $display("FAIL byte_cycle: n=%0d sel=%h padr=%h required 1/0020/00012345", acked.size(), acked.size() ? acked[0].sel : 16'h0, acked.size() ? acked[0].padr : 32'h0); end
        exp_tid = tid_next(exp_tid);
    endtask

    task automatic test_split_write();
        int nr, ne, lat, nc; logic b1; logic [31:0] rd;
        run_access(1'b1, BIU_DWORD, 32'h0000000E, 32'h44332211, nr, ne, lat, nc, b1, rd);
        tests++; if (acked.size() != 2) begin fails++; $display("FAIL split_count: got %0d cycles required 2", acked.size()); end
        else begin
            tests++; if (acked[0].sel !== 16'hC000 || acked[0].data !== {16'h2211, 112'h0} || acked[0].padr !== 32'hE) begin
                fails++; $display("FAIL split_part1: padr=%h sel=%h data=%h required 0000000e/c000/2211<<112", acked[0].padr, acked[0].sel, acked[0].data); end
            tests++; if (acked[1].sel !== 16'h0003 || acked[1].data !== {112'h0, 16'h4433} || acked[1].padr !== 32'h10) begin
                fails++; $display("FAIL split_part2: padr=%h sel=%h data=%h required 00000010/0003/4433", acked[1].padr, acked[1].sel, acked[1].data); end
        end
        tests++; if (nr != 1 || lat != 5) begin fails++; $display("FAIL split_done: rdy=%0d lat=%0d required 1/5", nr, lat); end
        exp_tid = tid_next(tid_next(exp_tid));
    endtask

    task automatic test_retry();
        int nr, ne, lat, nc; logic b1; logic [31:0] rd;
        test_reset();
        rty_plan = 2;
        model_access(BIU_WORD, 32'h100, 32'h0);
        run_access(1'b0, BIU_WORD, 32'h100, 32'h0, nr, ne, lat, nc, b1, rd);
        rty_plan = 0;
        tests++; if (iss_tid.size() != 3) begin fails++; $display("FAIL retry_issues: got %0d required 3", iss_tid.size()); end
        else for (int i = 0; i < 3; i++) begin
            tests++; if (iss_tid[i] !== 4'(i + 1)) begin fails++; $display("FAIL retry_tid%0d: got %0d required %0d", i, iss_tid[i], i + 1); end
        end
        tests++; if (nr != 1 || ne != 0 || rd !== exp_rd) begin fails++; $display("FAIL retry_done: rdy=%0d err=%0d rdat=%h required 1/0/%h", nr, ne, rd, exp_rd); end
        exp_tid = 4'd4;
    endtask

    task automatic test_retry_limit();
        int nr, ne, lat, nc; logic b1; logic [31:0] rd;
        always_rty = 1;
        run_access(1'b0, BIU_BYTE, 32'h200, 32'h0, nr, ne, lat, nc, b1, rd);
        always_rty = 0;
        tests++; if (iss_tid.size() != 3) begin fails++; $display("FAIL rtylim_issues: got %0d required 3", iss_tid.size()); end
        tests++; if (ne != 1 || nr != 0) begin fails++; $display("FAIL rtylim_result: err=%0d rdy=%0d required 1/0", ne, nr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rtylim_busy: got %b required 0", busy); end
        for (int i = 0; i < 3; i++) exp_tid = tid_next(exp_tid);
    endtask

    task automatic test_reserved();
        int nr, ne, lat, nc; logic b1; logic [31:0] rd;
        run_access(1'b0, 2'd3, 32'h300, 32'h0, nr, ne, lat, nc, b1, rd);
        tests++; if (ne != 1 || lat != 1 || nr != 0) begin fails++; $display("FAIL reserved_err: err=%0d lat=%0d rdy=%0d required 1/1/0", ne, lat, nr); end
        tests++; if (nc != 0 || iss_tid.size() != 0 || b1 !== 1'b0) begin fails++; $display("FAIL reserved_bus: cyc=%0d issues=%0d busy=%b required 0/0/0", nc, iss_tid.size(), b1); end
    endtask

    task automatic test_reset_mid();
        int bad = 0, nr, ne, lat, nc; logic b1; logic [31:0] rd;
        bit reached = 0;
        acked.delete(); iss_tid.delete();
        resp_budget = 1;
        req = 1'b1; we = 1'b0; size = BIU_DWORD; adr = 32'h0000000E;
        tick();
        req = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (rdy || err) bad++;
            if (iss_tid.size() >= 2 && ftam_req.cyc) begin reached = 1; break; end
            tick();
        end
        tests++; if (!reached) begin fails++; $display("FAIL rstmid_cyc2: second cycle not reached, issues=%0d required 2", iss_tid.size()); end
        rst = 1'b1;
        tick();
        tests++; if (ftam_req.cyc !== 1'b0 || ftam_req.tid.tranid !== 4'd1 || busy !== 1'b0) begin
            fails++; $display("FAIL rstmid_drop: cyc=%b tranid=%0d busy=%b required 0/1/0", ftam_req.cyc, ftam_req.tid.tranid, busy); end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin if (rdy || err) bad++; tick(); end
        tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_pulse: %0d rdy/err cycles required 0", bad); end
        resp_budget = -1;
        exp_tid = 4'd1;
        run_access(1'b0, BIU_BYTE, 32'h12345, 32'h0, nr, ne, lat, nc, b1, rd);
        tests++; if (nr != 1 || rd !== 32'hA5 || lat != 3 || iss_tid.size() != 1 || iss_tid[0] !== 4'd1) begin
            fails++; $display("FAIL rstmid_after: rdy=%0d rdat=%h lat=%0d issues=%0d required 1/a5/3/1 tid1", nr, rd, lat, iss_tid.size()); end
        exp_tid = 4'd2;
    endtask

    task automatic test_wrap();
        int nr, ne, lat, nc; logic b1; logic [31:0] rd;
        model_access(BIU_WORD, 32'hFFFFFFFF, 32'h0);
        run_access(1'b0, BIU_WORD, 32'hFFFFFFFF, 32'h0, nr, ne, lat, nc, b1, rd);
        tests++; if (acked.size() != 2) begin fails++; $display("FAIL wrap_count: got %0d required 2", acked.size()); end
        else begin
            tests++; if (acked[0].padr !== 32'hFFFFFFFF || acked[0].sel !== 16'h8000 || acked[1].padr !== 32'h0 || acked[1].sel !== 16'h0001) begin
                fails++; $display("FAIL wrap_parts: %h/%h %h/%h required ffffffff/8000 00000000/0001", acked[0].padr, acked[0].sel, acked[1].padr, acked[1].sel); end
        end
        tests++; if (nr != 1 || rd !== exp_rd) begin fails++; $display("FAIL wrap_rdat: rdy=%0d rdat=%h required 1/%h", nr, rd, exp_rd); end
        exp_tid = tid_next(tid_next(exp_tid));
    endtask

    task automatic test_random();
        int nr, ne, lat, nc; logic b1; logic [31:0] rd;
        logic w; logic [1:0] sz; logic [31:0] a, d;
        for (int it = 0; it < 60; it++) begin
            w  = 1'($urandom_range(1, 0));
            sz = 2'($urandom_range(2, 0));
            a  = $urandom;
            d  = $urandom;
            max_wait     = int'($urandom_range(2, 0));
            rty_plan     = int'($urandom_range(2, 0));
            ack_with_rty = 1'($urandom_range(1, 0));
            model_access(sz, a, d);
            run_access(w, sz, a, d, nr, ne, lat, nc, b1, rd);
            tests++; if (nr != 1 || ne != 0 || b1 !== 1'b1) begin fails++; $display("FAIL rnd%0d_done: rdy=%0d err=%0d busy=%b required 1/0/1", it, nr, ne, b1); end
            tests++; if (acked.size() != exp_np) begin fails++; $display("FAIL rnd%0d_parts: got %0d required %0d", it, acked.size(), exp_np); end
            else for (int p = 0; p < exp_np; p++) begin
                tests++; if (acked[p].padr !== exp_pa[p] || acked[p].sel !== exp_ps[p] || (w && acked[p].data !== exp_pd[p])) begin
                    fails++; $display("FAIL rnd%0d_part%0d: padr=%h sel=%h data=%h required %h/%h/%h", it, p, acked[p].padr, acked[p].sel, acked[p].data, exp_pa[p], exp_ps[p], exp_pd[p]); end
            end
            if (!w) begin
                tests++; if (rd !== exp_rd) begin fails++; $display("FAIL rnd%0d_rdat: got %h required %h", it, rd, exp_rd); end
            end
            tests++; if (iss_tid.size() != exp_np * (rty_plan + 1)) begin fails++; $display("FAIL rnd%0d_issues: got %0d required %0d", it, iss_tid.size(), exp_np * (rty_plan + 1)); end
            foreach (iss_tid[i]) begin
                tests++; if (iss_tid[i] !== exp_tid) begin fails++; $display("FAIL rnd%0d_tid%0d: got %0d required %0d", it, i, iss_tid[i], exp_tid); end
                exp_tid = tid_next(exp_tid);
            end
        end
        max_wait = 0; rty_plan = 0; ack_with_rty = 0;
    endtask

    initial begin
        test_reset();
        test_byte_read();
        test_split_write();
        test_retry();
        test_retry_limit();
        test_reserved();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_fta_biu.md
Name: rf_fta_biu

Overview:
- Parametrised bus interface unit for the rf8088/rf80386 cores.
- Converts one CPU data access (byte, word or dword, any alignment) into FTA 128-bit classic bus cycles.
- Replaces the core's inline per-byte bus tasks. Adds lane steering, splitting of accesses that cross a 16-byte line, retry on rty with a retry limit, and transaction-ID sequencing.
- Sits between the CPU state machine and the fta_cmd_request128_t / fta_cmd_response128_t master port.

Parameters:
- CORENO, 6'd1, core number placed in ftam_req.tid.core.
- CID, 3'd1, channel placed in ftam_req.tid.channel.
- AWID, 20, CPU address width: 20 for 8088, 32 for 386. Legal range 20..32.
- RTY_MAX, 4'd15, maximum rty responses accepted per bus cycle before the access aborts with an error.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, synchronous active-high reset.
- req_i, input, 1, single-cycle access request. Sampled only while busy_o=0.
- we_i, input, 1, 1=write, 0=read.
- size_i, input, 2, access size: 0=byte, 1=word, 2=dword, 3=reserved.
- adr_i, input, AWID, byte address.
- wdat_i, input, 32, write data, little-endian.
- busy_o, output, 1, access in progress.
- rdy_o, output, 1, one-cycle completion pulse.
- rdat_o, output, 32, read data, zero-extended. Valid when rdy_o=1 and held until the next access completes.
- err_o, output, 1, one-cycle abort pulse.
- ftam_req, output, fta_cmd_request128_t, bus request.
- ftam_resp, input, fta_cmd_response128_t, bus response.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - cyc, stb, we and sel are cleared; all other ftam_req fields are 0.
  - tid.core=CORENO, tid.channel=CID, tid.tranid=1.
  - busy_o=0, rdy_o=0, err_o=0, rdat_o=0.
  - Reset mid-access drops cyc/stb at the next edge. No rdy_o or err_o is produced.
- Lane and split computation:
  - n = 1<<size_i; off = adr_i[3:0].
  - split = (off+n > 16).
  - Part 1: address adr_i, length min(n, 16-off).
  - Part 2: address (adr_i | 4'hF)+1, taken modulo 2^AWID; length is the remainder.
- Bus cycle fields:
  - blen=0, bte=LINEAR, cti=CLASSIC.
  - sel = byte mask of the part length, shifted left by the lane offset, truncated to 16 bits.
  - padr = vadr = address zero-extended to 32 bits.
  - data1 = the part's write bytes shifted to their byte lanes; unused lanes are 0.
  - we follows we_i.
- State machine: IDLE -> CYC1 -> GAP -> (CYC2 -> GAP) -> DONE -> IDLE.
  - IDLE: req_i with size_i=3 pulses err_o the next cycle and issues no bus cycle. Any other req_i latches all inputs, sets busy_o and goes to CYC1.
  - CYC1/CYC2: cyc=stb=1 with the computed fields. The state waits indefinitely for ack or rty.
  - ack: read lanes are captured into the matching bytes of the result register. cyc/stb drop; the next state is GAP.
  - rty: cyc/stb drop; the retry count increments. If the count exceeds RTY_MAX, go to IDLE with an err_o pulse. Otherwise the same cycle is reissued after one idle clock.
  - ack and rty asserted together: ack wins.
  - GAP: one idle clock. Go to CYC2 if split and part 2 is pending; otherwise go to DONE.
  - DONE: rdy_o=1 and rdat_o is updated. busy_o returns to 0 at the same edge.
- The retry count resets at the start of each part.
- tranid increments on each new issue, including retries. It wraps 15 -> 1; value 0 is never used.
- req_i pulses while busy_o=1 are dropped.
- Latency for an unsplit access, no retry, with req_i at cycle 0:
  - cyc high from cycle 1.
  - ack sampled at cycle k.
  - rdy_o at cycle k+2.
- A split access adds the second cycle plus one GAP clock.

Decomposition:
- Shared package rf_biu_pkg holds:
  - e_biu_state enum (IDLE, CYC1, GAP, CYC2, DONE);
  - size encodings BIU_BYTE/BIU_WORD/BIU_DWORD;
  - a function returning the 16-bit lane mask for (off, len).
- One sub-module, rf_biu_lane_steer: combinational. Takes (off, len, wdat) and produces (sel, data1); it also shifts ftam_resp.dat back to byte order. It is instantiated once and driven by the current part.
- The sequencing logic stays in rf_fta_biu.

Test Plan:
- Aligned byte read: adr=20'h12345, size=0, slave acks with byte 0xA5 on lane 5 -> one cycle, sel=16'h0020, rdy_o with rdat_o=32'h000000A5.
- Split dword write: adr=20'h0000E, wdat=32'h44332211 -> cycle 1 sel=16'hC000 with lanes 14/15=11,22; GAP; cycle 2 padr=20'h00010, sel=16'h0003, lanes 0/1=33,44; then a single rdy_o.
- Retry: slave answers rty twice, then ack, on a word read at 20'h00100 -> three issues with tranid 1,2,3; rdy_o once.
- Retry limit: RTY_MAX=2, slave always rty -> three issues, then an err_o pulse, no rdy_o, busy_o=0.
- Reserved size: size_i=3 -> err_o the next cycle, cyc never asserted.
- Reset mid-access: rst_i asserted while CYC2 is waiting -> cyc=0 next edge, tranid=1, no rdy_o or err_o. A new byte read then completes normally. AWID=32 with wrap case adr=32'hFFFFFFFF, size=1 -> part 2 padr=32'h00000000.
